// File: rtl/keccak_ibytes_tx_pkg.sv
// keccak_ibytes_tx_pkg: shared keccak widths (BW_DATA, BW_IBLEN, MAX_IBYTES) and transmitter state encodings
`ifndef KECCAK_DEFINES
`define KECCAK_DEFINES
`define BW_DATA 64
`define BW_IBLEN 11
`define MAX_IBYTES 1184
`define TX_IDLE 2'd0
`define TX_PACK 2'd1
`define TX_SEND 2'd2
`define TX_DONE 2'd3
`endif
package keccak_ibytes_tx_pkg;
  typedef enum logic [1:0] {
    TX_IDLE = `TX_IDLE,
    TX_PACK = `TX_PACK,
    TX_SEND = `TX_SEND,
    TX_DONE = `TX_DONE
  } tx_state_e;
endpackage

// File: rtl/keccak_word_packer.sv
// keccak_word_packer: MSB-first byte lane insert register with zero fill and 3-bit byte counter
// Ports: i_clk/i_rstn clock and sync active-low reset; i_clr restarts the word; i_load inserts
// i_byte at lane o_cnt; o_next is the word including the byte being inserted this cycle.
module keccak_word_packer #(
  parameter int BW_DATA = `BW_DATA
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [7:0]         i_byte,
  output logic [BW_DATA-1:0] o_next,
  output logic [2:0]         o_cnt
);
  logic [BW_DATA-1:0] word;
  // a fresh word starts from zero, so the unused tail of a partial word is already padding
  assign o_next = (o_cnt == 3'd0 ? '0 : word) | ({i_byte, {(BW_DATA-8){1'b0}}} >> {o_cnt, 3'b000});
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clr) begin
      word  <= '0;
      o_cnt <= '0;
    end else if (i_load) begin
      word  <= o_next;
      o_cnt <= o_cnt + 3'd1;
    end
  end
endmodule

// File: rtl/keccak_ibytes_tx.sv
// keccak_ibytes_tx: packs an upstream byte stream MSB-first into zero-padded words for keccak absorb
// Ports: i_clk/i_rstn clock and sync active-low reset; i_start/i_ibytes_len start a message;
// i_byte/i_byte_valid/o_byte_ready byte input; o_ibytes/o_ibytes_valid/i_ibytes_ready/o_ibytes_len
// word output to keccak; o_busy while a message is in flight; o_done one-cycle completion pulse.
// Option: define KECCAK_TX_SKID_EN for a second word register so packing overlaps a stalled word.
module keccak_ibytes_tx
  import keccak_ibytes_tx_pkg::*;
#(
  parameter int BW_DATA  = `BW_DATA,
  parameter int BW_IBLEN = `BW_IBLEN
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [BW_IBLEN-1:0] i_ibytes_len,
  input  logic [7:0]          i_byte,
  input  logic                i_byte_valid,
  output logic                o_byte_ready,
  output logic [BW_DATA-1:0]  o_ibytes,
  output logic                o_ibytes_valid,
  input  logic                i_ibytes_ready,
  output logic [BW_IBLEN-1:0] o_ibytes_len,
  output logic                o_busy,
  output logic                o_done
);
  tx_state_e           state;
  logic [BW_IBLEN-1:0] bytes_left, bl_n;
  logic [BW_DATA-1:0]  pk_next;
  logic [2:0]          pk_cnt;
  logic                accept, word_end, out_fire;
  assign accept   = i_byte_valid && o_byte_ready;
  assign word_end = accept && (pk_cnt == 3'd7 || bytes_left == BW_IBLEN'(1));
  assign out_fire = o_ibytes_valid && i_ibytes_ready;
  assign bl_n     = bytes_left - BW_IBLEN'(accept);
`ifdef KECCAK_TX_SKID_EN
  logic [BW_DATA-1:0] skid_word;
  logic               skid_full, skid_full_n, out_free;
  assign out_free    = !o_ibytes_valid || out_fire;
  assign skid_full_n = skid_full ? !out_free : (word_end && !out_free);
`endif
  keccak_word_packer #(.BW_DATA(BW_DATA)) u_packer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  ((state == TX_IDLE && i_start) || word_end),
    .i_load (accept),
    .i_byte (i_byte),
    .o_next (pk_next),
    .o_cnt  (pk_cnt)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state          <= TX_IDLE;
      bytes_left     <= '0;
      o_ibytes       <= '0;
      o_ibytes_valid <= 1'b0;
      o_ibytes_len   <= '0;
      o_byte_ready   <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
`ifdef KECCAK_TX_SKID_EN
      skid_word      <= '0;
      skid_full      <= 1'b0;
`endif
    end else begin
      case (state)
        TX_IDLE: if (i_start) begin
          o_ibytes_len <= i_ibytes_len;
          bytes_left   <= i_ibytes_len;
          o_busy       <= 1'b1;
          o_byte_ready <= i_ibytes_len != '0;
          state        <= i_ibytes_len != '0 ? TX_PACK : TX_DONE;
        end
`ifdef KECCAK_TX_SKID_EN
        // PACK accepts bytes, SEND only drains; both keep the output/skid pair moving in order
        TX_PACK, TX_SEND: begin
          bytes_left <= bl_n;
          if (out_free && skid_full) begin
            o_ibytes       <= skid_word;
            o_ibytes_valid <= 1'b1;
          end else if (out_free && word_end) begin
            o_ibytes       <= pk_next;
            o_ibytes_valid <= 1'b1;
          end else if (out_fire) o_ibytes_valid <= 1'b0;
          if (word_end && !out_free) skid_word <= pk_next;
          skid_full    <= skid_full_n;
          o_byte_ready <= bl_n != '0 && !skid_full_n;
          if (state == TX_PACK && bl_n == '0) state <= TX_SEND;
          if (state == TX_SEND && !skid_full && out_fire) begin
            state  <= TX_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end
        end
`else
        TX_PACK: begin
          bytes_left <= bl_n;
          if (word_end) begin
            o_ibytes       <= pk_next;
            o_ibytes_valid <= 1'b1;
            o_byte_ready   <= 1'b0;
            state          <= TX_SEND;
          end
        end
        TX_SEND: if (out_fire) begin
          o_ibytes_valid <= 1'b0;
          if (bytes_left != '0) begin
            o_byte_ready <= 1'b1;
            state        <= TX_PACK;
          end else begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= TX_DONE;
          end
        end
`endif
        // entered with o_done already set after a word, or clear for a zero-length message
        TX_DONE: begin
          o_done <= !o_done;
          o_busy <= 1'b0;
          if (o_done) state <= TX_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keccak_ibytes_tx.sv
// tb_keccak_ibytes_tx: directed self-checking bench for keccak_ibytes_tx
module tb_keccak_ibytes_tx;
  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, byte_valid = 1'b0, ibytes_ready = 1'b0;
  logic [10:0] len = '0;
  logic [7:0]  din = '0;
  logic        byte_ready, ibytes_valid, busy, done;
  logic [63:0] ibytes;
  logic [10:0] ibytes_len;
  int          nvec = 0, nerr = 0;
  logic [7:0]  msg [0:1183];
  logic [63:0] got [$];
  int          acc, dones, done_cyc, hs_cyc, stall_acc, stalls, unstable, len_bad, busy_bad, cyc;
  always #5 clk = ~clk;
  keccak_ibytes_tx dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_start        (start),
    .i_ibytes_len   (len),
    .i_byte         (din),
    .i_byte_valid   (byte_valid),
    .o_byte_ready   (byte_ready),
    .o_ibytes       (ibytes),
    .o_ibytes_valid (ibytes_valid),
    .i_ibytes_ready (ibytes_ready),
    .o_ibytes_len   (ibytes_len),
    .o_busy         (busy),
    .o_done         (done)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] model_word(input int n, input int w);
    logic [63:0] r = '0;
    for (int b = 0; b < 8; b++) if (8 * w + b < n) r[63-8*b -: 8] = msg[8*w+b];
    return r;
  endfunction
  // one message: bytes offered every cycle (extra 0xA5 bytes past the end), optional stall on one word
  task automatic run(input int n, input int stall_word, input int stall_n, input int rst_at);
    int idx = 0, wi = 0;
    bit fin = 0;
    logic [63:0] held = '0;
    got.delete();
    acc = 0; dones = 0; done_cyc = -1; hs_cyc = -1; stall_acc = 0; stalls = 0;
    unstable = 0; len_bad = 0; busy_bad = 0; cyc = 0;
    tick();
    start = 1'b1;
    len = n[10:0];
    tick();
    start = 1'b0;
    while (!fin && cyc < 20000) begin
      din = idx < n ? msg[idx] : 8'hA5;
      byte_valid = 1'b1;
      ibytes_ready = !(ibytes_valid && wi == stall_word && stalls < stall_n);
      @(negedge clk);
      if (ibytes_len !== n[10:0]) len_bad++;
      if (done ? busy : !busy) busy_bad++;
      if (byte_ready) begin
        acc++;
        idx++;
      end
      if (ibytes_valid && !ibytes_ready) begin
        if (stalls > 0 && ibytes !== held) unstable++;
        held = ibytes;
        stalls++;
        if (byte_ready) stall_acc++;
      end else if (ibytes_valid) begin
        got.push_back(ibytes);
        wi++;
        hs_cyc = cyc;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        fin = 1;
      end
      if (rst_at >= 0 && acc >= rst_at) fin = 1;
      tick();
      cyc++;
    end
    byte_valid = 1'b0;
    ibytes_ready = 1'b0;
    nvec++;
    if (!fin) begin
      nerr++;
      $display("FAIL timeout: no o_done within %0d cycles (len %0d)", cyc, n);
    end
  endtask
  task automatic check_tail(input string name, input int n, input int words);
    nvec++;
    if (acc !== n) begin nerr++; $display("FAIL %s accepted: got %0d expected %0d", name, acc, n); end
    nvec++;
    if (got.size() !== words) begin nerr++; $display("FAIL %s words: got %0d expected %0d", name, got.size(), words); end
    nvec++;
    if (dones !== 1) begin nerr++; $display("FAIL %s dones: got %0d expected 1", name, dones); end
    nvec++;
    if (len_bad !== 0 || busy_bad !== 0) begin nerr++; $display("FAIL %s len/busy: got %0d/%0d bad cycles expected 0", name, len_bad, busy_bad); end
    @(negedge clk);
    nvec++;
    if (done !== 1'b0) begin nerr++; $display("FAIL %s done pulse: got %b expected 0", name, done); end
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    start = 1'b1;
    len = 11'd8;
    repeat (3) tick();
    @(negedge clk);
    nvec++;
    if (ibytes !== 64'h0) begin nerr++; $display("FAIL reset o_ibytes: got %h expected 0", ibytes); end
    nvec++;
    if (ibytes_len !== 11'd0) begin nerr++; $display("FAIL reset o_ibytes_len: got %0d expected 0", ibytes_len); end
    nvec++;
    if ({ibytes_valid, byte_ready, busy, done} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset flags valid/ready/busy/done: got %b expected 0000", {ibytes_valid, byte_ready, busy, done});
    end
    start = 1'b0;
    rstn = 1'b1;
    tick();
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL reset start ignored: busy %b expected 0", busy); end
  endtask
  task automatic test_exact();
    for (int i = 0; i < 8; i++) msg[i] = 8'(i);
    run(8, -1, 0, -1);
    nvec++;
    if (got[0] !== 64'h0001020304050607) begin nerr++; $display("FAIL exact word0: got %h expected 0001020304050607", got[0]); end
    nvec++;
    if (done_cyc !== hs_cyc + 1) begin nerr++; $display("FAIL exact done timing: got cycle %0d expected %0d", done_cyc, hs_cyc + 1); end
    check_tail("exact", 8, 1);
  endtask
  task automatic test_partial();
    for (int i = 0; i < 13; i++) msg[i] = 8'(i);
    run(13, -1, 0, -1);
    nvec++;
    if (got[0] !== 64'h0001020304050607) begin nerr++; $display("FAIL partial word0: got %h expected 0001020304050607", got[0]); end
    nvec++;
    if (got[1] !== 64'h08090A0B0C000000) begin nerr++; $display("FAIL partial word1: got %h expected 08090a0b0c000000", got[1]); end
    nvec++;
    if (done_cyc !== hs_cyc + 1) begin nerr++; $display("FAIL partial done timing: got cycle %0d expected %0d", done_cyc, hs_cyc + 1); end
    check_tail("partial", 13, 2);
  endtask
  task automatic test_zero();
    run(0, -1, 0, -1);
    nvec++;
    if (done_cyc !== 1) begin nerr++; $display("FAIL zero done timing: got cycle %0d expected 1", done_cyc); end
    check_tail("zero", 0, 0);
  endtask
  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) msg[i] = 8'(i + 16);
    run(16, 0, 5, -1);
    nvec++;
    if (stalls !== 5) begin nerr++; $display("FAIL bp stall cycles: got %0d expected 5", stalls); end
    nvec++;
    if (unstable !== 0) begin nerr++; $display("FAIL bp word stable: got %0d changes expected 0", unstable); end
    nvec++;
    if (got[0] !== 64'h1011121314151617) begin nerr++; $display("FAIL bp word0: got %h expected 1011121314151617", got[0]); end
    nvec++;
    if (got[1] !== 64'h18191A1B1C1D1E1F) begin nerr++; $display("FAIL bp word1: got %h expected 18191a1b1c1d1e1f", got[1]); end
    nvec++;
`ifdef KECCAK_TX_SKID_EN
    if (stall_acc !== 5) begin nerr++; $display("FAIL bp skid bytes during stall: got %0d expected 5", stall_acc); end
`else
    if (stall_acc !== 0) begin nerr++; $display("FAIL bp bytes during stall: got %0d expected 0", stall_acc); end
`endif
    check_tail("bp", 16, 2);
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 24; i++) msg[i] = 8'(8'hC0 + i);
    run(24, -1, 0, 10);
    rstn = 1'b0;
    tick();
    @(negedge clk);
    nvec++;
    if ({ibytes, ibytes_len} !== 75'h0) begin nerr++; $display("FAIL rstmid data: got %h/%0d expected 0/0", ibytes, ibytes_len); end
    nvec++;
    if ({ibytes_valid, byte_ready, busy, done} !== 4'b0000) begin
      nerr++;
      $display("FAIL rstmid flags: got %b expected 0000", {ibytes_valid, byte_ready, busy, done});
    end
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) msg[i] = 8'(8'h50 + i);
    run(8, -1, 0, -1);
    nvec++;
    if (got[0] !== 64'h5051525354555657) begin nerr++; $display("FAIL rstmid rerun word: got %h expected 5051525354555657", got[0]); end
    check_tail("rstmid", 8, 1);
  endtask
  task automatic test_max();
    for (int i = 0; i < 1184; i++) msg[i] = 8'($urandom);
    run(1184, -1, 0, -1);
    for (int w = 0; w < 148; w++) begin
      nvec++;
      if (got[w] !== model_word(1184, w)) begin
        nerr++;
        $display("FAIL max word%0d: got %h expected %h", w, got[w], model_word(1184, w));
      end
    end
    check_tail("max", 1184, 148);
  endtask
  initial begin
    test_reset();
    test_exact();
    test_partial();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_max();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
